// File: rtl/lfa_adc_sampler_if.sv
// SPI bus between the LFA sampler (master) and the ADC128S022 (slave).
interface lfa_adc_sampler_if;
    logic adc_cs_n;
    logic adc_sck;
    logic adc_din;
    logic adc_dout;

    modport master (
        output adc_cs_n,
        output adc_sck,
        output adc_din,
        input  adc_dout
    );

    modport slave (
        input  adc_cs_n,
        input  adc_sck,
        input  adc_din,
        output adc_dout
    );
endinterface

// File: rtl/lfa_adc_sampler.sv
// Line-follower-array sampler: drives the ADC128S022 over SPI at clk/2,
// walks the left/middle/right channels in turn and publishes all three
// 12-bit readings together with a one-cycle sample_valid strobe.
// The ADC returns the conversion of the channel addressed in the previous
// frame, so the word shifted in during a frame belongs to the previous slot.
// The first frame after reset or restart only primes the ADC and is dropped.
module lfa_adc_sampler #(
    parameter logic [2:0] CH_LEFT   = 3'd3,
    parameter logic [2:0] CH_MIDDLE = 3'd2,
    parameter logic [2:0] CH_RIGHT  = 3'd1,
    parameter int         CS_GAP    = 2
) (
    input  logic                     clk_3125KHz,
    input  logic                     rst_n,
    input  logic                     enable,
    lfa_adc_sampler_if.master        adc,
    output logic [11:0]              left,
    output logic [11:0]              middle,
    output logic [11:0]              right,
    output logic                     sample_valid,
    output logic                     busy
);

    // The counter walks 32 shift phases and the CS gap, whichever is longer.
    localparam int CNT_W = (CS_GAP > 32) ? $clog2(CS_GAP) : 5;
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(31);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SLOT_LEFT   = 2'd0,
        SLOT_MIDDLE = 2'd1,
        SLOT_RIGHT  = 2'd2
    } slot_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;

    slot_t            slot;
    slot_t            data_slot;
    logic             data_live;
    logic             have_left;
    logic             have_middle;

    logic [11:0]      shift_reg;
    logic [11:0]      shadow_left;
    logic [11:0]      shadow_middle;
    logic [11:0]      word;

    logic             cs_q;
    logic             sck_q;
    logic             din_q;
    logic             cs_next;
    logic             sck_next;
    logic             din_next;

    logic [2:0]       chan;
    logic [3:0]       bit_idx;
    logic             capture;
    logic             word_done;
    logic             frame_end;

    assign adc.adc_cs_n = cs_q;
    assign adc.adc_sck  = sck_q;
    assign adc.adc_din  = din_q;

    assign busy    = (state != IDLE);
    assign bit_idx = cnt[4:1];
    assign word    = {shift_reg[10:0], adc.adc_dout};

    // Channel address of the slot being addressed in the current frame.
    always_comb begin
        chan = CH_LEFT;
        case (slot)
            SLOT_MIDDLE: chan = CH_MIDDLE;
            SLOT_RIGHT:  chan = CH_RIGHT;
            default:     chan = CH_LEFT;
        endcase
    end

    // Next state plus next SPI pin levels and the frame event strobes.
    always_comb begin
        state_next = state;
        cs_next    = cs_q;
        sck_next   = sck_q;
        din_next   = din_q;
        capture    = 1'b0;
        word_done  = 1'b0;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                cs_next  = 1'b1;
                sck_next = 1'b1;
                if (enable) begin
                    state_next = START;
                end
            end
            START: begin
                cs_next    = 1'b0;
                state_next = SHIFT;
            end
            SHIFT: begin
                if (!cnt[0]) begin
                    sck_next = 1'b0;
                    case (bit_idx)
                        4'd2:    din_next = chan[2];
                        4'd3:    din_next = chan[1];
                        4'd4:    din_next = chan[0];
                        default: din_next = 1'b0;
                    endcase
                end else begin
                    sck_next  = 1'b1;
                    capture   = (bit_idx >= 4'd4);
                    word_done = (cnt == SHIFT_LAST);
                end
                if (cnt == SHIFT_LAST) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                cs_next  = 1'b1;
                sck_next = 1'b1;
                if (cnt == GAP_LAST) begin
                    frame_end  = 1'b1;
                    state_next = enable ? START : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and the phase counter, which restarts on every state change.
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if ((state_next != state) || (state == IDLE)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Registered SPI pins so the ADC sees glitch-free edges.
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            cs_q  <= 1'b1;
            sck_q <= 1'b1;
            din_q <= 1'b0;
        end else begin
            cs_q  <= cs_next;
            sck_q <= sck_next;
            din_q <= din_next;
        end
    end

    // Shift in conversion bits, file each finished word by slot, publish on right.
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg     <= '0;
            shadow_left   <= '0;
            shadow_middle <= '0;
            have_left     <= 1'b0;
            have_middle   <= 1'b0;
            left          <= '0;
            middle        <= '0;
            right         <= '0;
            sample_valid  <= 1'b0;
            slot          <= SLOT_LEFT;
            data_slot     <= SLOT_LEFT;
            data_live     <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (capture) begin
                shift_reg <= word;
            end
            if (word_done && data_live) begin
                case (data_slot)
                    SLOT_LEFT: begin
                        shadow_left <= word;
                        have_left   <= 1'b1;
                    end
                    SLOT_MIDDLE: begin
                        shadow_middle <= word;
                        have_middle   <= 1'b1;
                    end
                    SLOT_RIGHT: begin
                        if (have_left && have_middle) begin
                            left         <= shadow_left;
                            middle       <= shadow_middle;
                            right        <= word;
                            sample_valid <= 1'b1;
                        end
                        have_left   <= 1'b0;
                        have_middle <= 1'b0;
                    end
                    default: begin
                        have_left   <= 1'b0;
                        have_middle <= 1'b0;
                    end
                endcase
            end
            if (frame_end) begin
                if (enable) begin
                    data_slot <= slot;
                    data_live <= 1'b1;
                    case (slot)
                        SLOT_LEFT:   slot <= SLOT_MIDDLE;
                        SLOT_MIDDLE: slot <= SLOT_RIGHT;
                        default:     slot <= SLOT_LEFT;
                    endcase
                end else begin
                    slot        <= SLOT_LEFT;
                    data_live   <= 1'b0;
                    have_left   <= 1'b0;
                    have_middle <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfa_adc_sampler.sv
// Bench for lfa_adc_sampler: behavioural ADC128S022 models on two buses, a
// frame-timeline reference for the default build and a CS_GAP=5 build.
module tb_lfa_adc_sampler;

    localparam int F  = 35;
    localparam int FB = 38;
    localparam int NEVER = 1000000;

    logic clk;
    logic rst_n;
    logic enable;

    logic [11:0] left_a, middle_a, right_a;
    logic        valid_a, busy_a;
    logic [11:0] left_b, middle_b, right_b;
    logic        valid_b, busy_b;

    lfa_adc_sampler_if bus_a();
    lfa_adc_sampler_if bus_b();

    logic [11:0] adc_val [8];

    int tests;
    int failures;

    int t;
    bit running;
    int stop_t;
    bit check_b;
    int pub_count;
    logic [11:0] exp_left, exp_middle, exp_right;

    lfa_adc_sampler dut_a (
        .clk_3125KHz  (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .adc          (bus_a.master),
        .left         (left_a),
        .middle       (middle_a),
        .right        (right_a),
        .sample_valid (valid_a),
        .busy         (busy_a)
    );

    lfa_adc_sampler #(.CS_GAP(5)) dut_b (
        .clk_3125KHz  (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .adc          (bus_b.master),
        .left         (left_b),
        .middle       (middle_b),
        .right        (right_b),
        .sample_valid (valid_b),
        .busy         (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ADC on bus A: replies with the channel latched in the previous frame.
    initial begin : adc_model_a
        int         bitn;
        logic [2:0] addr;
        logic [2:0] ch;
        logic [11:0] word;
        logic [3:0] bi;
        logic [1:0] ai;
        bus_a.adc_dout = 1'b0;
        ch = 3'd0;
        forever begin
            @(negedge bus_a.adc_cs_n);
            word = adc_val[ch];
            bitn = 0;
            addr = 3'd0;
            while (bus_a.adc_cs_n == 1'b0) begin
                @(bus_a.adc_sck or posedge bus_a.adc_cs_n);
                if (bus_a.adc_cs_n !== 1'b0) begin
                    ch = addr;
                end else if (bus_a.adc_sck == 1'b0) begin
                    bi = 4'(15 - bitn);
                    bus_a.adc_dout = (bitn >= 4) ? word[bi] : 1'b0;
                    bitn++;
                end else if (bitn >= 3 && bitn <= 5) begin
                    ai = 2'(5 - bitn);
                    addr[ai] = bus_a.adc_din;
                end
            end
        end
    end

    // Same ADC behaviour on bus B.
    initial begin : adc_model_b
        int         bitn;
        logic [2:0] addr;
        logic [2:0] ch;
        logic [11:0] word;
        logic [3:0] bi;
        logic [1:0] ai;
        bus_b.adc_dout = 1'b0;
        ch = 3'd0;
        forever begin
            @(negedge bus_b.adc_cs_n);
            word = adc_val[ch];
            bitn = 0;
            addr = 3'd0;
            while (bus_b.adc_cs_n == 1'b0) begin
                @(bus_b.adc_sck or posedge bus_b.adc_cs_n);
                if (bus_b.adc_cs_n !== 1'b0) begin
                    ch = addr;
                end else if (bus_b.adc_sck == 1'b0) begin
                    bi = 4'(15 - bitn);
                    bus_b.adc_dout = (bitn >= 4) ? word[bi] : 1'b0;
                    bitn++;
                end else if (bitn >= 3 && bitn <= 5) begin
                    ai = 2'(5 - bitn);
                    addr[ai] = bus_b.adc_din;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s at t=%0d: got %0h, expected %0h", tag, t, got, want);
        end
    endtask

    // One negedge sample per cycle against the frame timeline of the current run.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bit         act;
            bit         pub;
            int         c;
            int         k;
            int         slot;
            int         cb;
            logic [2:0] ch;
            logic       exp_din;
            @(negedge clk);
            act = running && (t < stop_t);
            pub = act && (t >= 3*F + 33) && (((t - 3*F - 33) % (3*F)) == 0);
            if (pub) begin
                exp_left   = adc_val[3];
                exp_middle = adc_val[2];
                exp_right  = adc_val[1];
            end
            checkOutput("sample_valid", 32'(valid_a), 32'(pub));
            checkOutput("busy", 32'(busy_a), 32'(act));
            checkOutput("left", 32'(left_a), 32'(exp_left));
            checkOutput("middle", 32'(middle_a), 32'(exp_middle));
            checkOutput("right", 32'(right_a), 32'(exp_right));
            if (act) begin
                c    = t % F;
                slot = (t / F) % 3;
                ch   = (slot == 0) ? 3'd3 : (slot == 1) ? 3'd2 : 3'd1;
                k    = (c - 2) / 2;
                exp_din = 1'b0;
                if (c >= 2 && c <= 33) begin
                    if (k == 2) exp_din = ch[2];
                    else if (k == 3) exp_din = ch[1];
                    else if (k == 4) exp_din = ch[0];
                end
                checkOutput("cs_n", 32'(bus_a.adc_cs_n), 32'((c >= 1 && c <= 33) ? 1'b0 : 1'b1));
                checkOutput("sck", 32'(bus_a.adc_sck), 32'((c >= 2 && c <= 32 && (c % 2) == 0) ? 1'b0 : 1'b1));
                checkOutput("din", 32'(bus_a.adc_din), 32'(exp_din));
            end else begin
                checkOutput("idle_cs_n", 32'(bus_a.adc_cs_n), 32'(1));
                checkOutput("idle_sck", 32'(bus_a.adc_sck), 32'(1));
                checkOutput("idle_din", 32'(bus_a.adc_din), 32'(0));
            end
            if (check_b && running && t <= 3*FB + 36) begin
                cb = t % FB;
                checkOutput("b_cs_n", 32'(bus_b.adc_cs_n), 32'((cb >= 1 && cb <= 33) ? 1'b0 : 1'b1));
                checkOutput("b_valid", 32'(valid_b), 32'(t == 3*FB + 33));
                checkOutput("b_busy", 32'(busy_b), 32'(1));
                if (t == 3*FB + 33) begin
                    checkOutput("b_left", 32'(left_b), 32'(12'hABC));
                    checkOutput("b_middle", 32'(middle_b), 32'(12'h123));
                    checkOutput("b_right", 32'(right_b), 32'(12'h7FF));
                end
            end
            if (pub) begin
                pub_count++;
                if (pub_count == 1) begin
                    adc_val[1] = 12'h000;
                end else begin
                    for (int j = 1; j < 4; j++) begin
                        adc_val[j] = 12'($urandom);
                    end
                end
            end
            if (running) t++;
        end
    endtask

    initial begin
        tests     = 0;
        failures  = 0;
        t         = 0;
        running   = 1'b0;
        stop_t    = NEVER;
        check_b   = 1'b1;
        pub_count = 0;
        exp_left   = 12'h000;
        exp_middle = 12'h000;
        exp_right  = 12'h000;
        for (int j = 0; j < 8; j++) begin
            adc_val[j] = 12'($urandom);
        end
        adc_val[3] = 12'hABC;
        adc_val[2] = 12'h123;
        adc_val[1] = 12'h7FF;
        rst_n  = 1'b0;
        enable = 1'b1;

        // Reset state, then run from release; drop enable in frame 7 (left data).
        applyStimulus(3);
        rst_n   = 1'b1;
        running = 1'b1;
        t       = 0;
        applyStimulus(7*F + 11);
        enable = 1'b0;
        stop_t = 8*F;
        applyStimulus(8*F - (7*F + 11) + 20);

        // Restart from idle, then assert reset mid-frame in a right-data frame.
        check_b = 1'b0;
        enable  = 1'b1;
        t       = 0;
        stop_t  = NEVER;
        applyStimulus(6*F + 21);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_cs_n", 32'(bus_a.adc_cs_n), 32'(1));
        checkOutput("rst_sck", 32'(bus_a.adc_sck), 32'(1));
        checkOutput("rst_din", 32'(bus_a.adc_din), 32'(0));
        checkOutput("rst_left", 32'(left_a), 32'(0));
        checkOutput("rst_middle", 32'(middle_a), 32'(0));
        checkOutput("rst_right", 32'(right_a), 32'(0));
        checkOutput("rst_valid", 32'(valid_a), 32'(0));
        checkOutput("rst_busy", 32'(busy_a), 32'(0));
        exp_left   = 12'h000;
        exp_middle = 12'h000;
        exp_right  = 12'h000;
        running    = 1'b0;
        applyStimulus(3);
        rst_n   = 1'b1;
        running = 1'b1;
        t       = 0;
        applyStimulus(6*F + 37);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
